// File: rtl/tone_pkg.sv
// Shared types and defaults for the tone player: FSM state encoding,
// default counter widths and the rest (silence) half-period value.
package tone_pkg;
   localparam int PERIOD_BITS_DEF = 18;
   localparam int DUR_BITS_DEF    = 4;
   localparam int REST            = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      FIN  = 2'd2
   } state_t;
endpackage

// File: rtl/tone_div.sv
// Loadable half-period divider: counts clocks while enabled and toggles its
// output each time the count reaches half_period-1. A zero half-period is a rest.
import tone_pkg::*;

module tone_div #(
   parameter int PERIOD_BITS = PERIOD_BITS_DEF
) (
   input  logic                   clk,
   input  logic                   r,
   input  logic                   load,
   input  logic                   clear,
   input  logic                   en,
   input  logic [PERIOD_BITS-1:0] half_period,
   output logic                   tone
);

   logic [PERIOD_BITS-1:0] hp_q;
   logic [PERIOD_BITS-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!r) begin
         hp_q <= '0;
         cnt  <= '0;
         tone <= 1'b0;
      end else if (load) begin
         hp_q <= half_period;
         cnt  <= '0;
         tone <= 1'b0;
      end else if (clear) begin
         cnt  <= '0;
         tone <= 1'b0;
      end else if (en && (hp_q != PERIOD_BITS'(REST))) begin
         if (cnt == hp_q - PERIOD_BITS'(1)) begin
            cnt  <= '0;
            tone <= ~tone;
         end else begin
            cnt <= cnt + PERIOD_BITS'(1);
         end
      end
   end

endmodule

// File: rtl/tone_player.sv
// Single-note square-wave player: accepts a note, toggles the speaker at the
// note's half-period and counts beat ticks. Optional macro TONE_GAP_EN silences the last beat.
//
// state | meaning
// IDLE  | waiting for a note, note_ready=1, speaker=0
// PLAY  | note in progress, tone divider and beat count running unless paused
// FIN   | one-cycle done pulse, speaker=0, then back to IDLE
import tone_pkg::*;

module tone_player #(
   parameter int PERIOD_BITS = PERIOD_BITS_DEF,
   parameter int DUR_BITS    = DUR_BITS_DEF
) (
   input  logic                   clk,
   input  logic                   r,
   input  logic                   beat,
   input  logic                   note_valid,
   output logic                   note_ready,
   input  logic [PERIOD_BITS-1:0] note_half_period,
   input  logic [DUR_BITS-1:0]    note_beats,
   input  logic                   pause,
   output logic                   speaker,
   output logic                   busy,
   output logic                   done
);

   state_t              state;
   logic [DUR_BITS-1:0] beats_q;
   logic [DUR_BITS-1:0] bcnt;
   logic                tone;
   logic                accept;
   logic                beat_in;
   logic                last_beat;
   logic                finish;

   assign accept    = (state == IDLE) && note_valid;
   assign beat_in   = (state == PLAY) && !pause && beat;
   assign last_beat = beat_in && (bcnt + DUR_BITS'(1) == beats_q);
   assign finish    = (state == PLAY) && ((beats_q == '0) || last_beat);

   tone_div #(
      .PERIOD_BITS (PERIOD_BITS)
   ) u_div (
      .clk         (clk),
      .r           (r),
      .load        (accept),
      .clear       (finish),
      .en          ((state == PLAY) && !pause),
      .half_period (note_half_period),
      .tone        (tone)
   );

`ifdef TONE_GAP_EN
   logic gap_q;

   // Gap opens once beats-1 beats are counted; the divider keeps running underneath.
   always_ff @(posedge clk) begin
      if (!r)
         gap_q <= 1'b0;
      else if (accept || finish)
         gap_q <= 1'b0;
      else if (beat_in && (beats_q >= DUR_BITS'(2)) &&
               (bcnt + DUR_BITS'(2) == beats_q))
         gap_q <= 1'b1;
   end

   assign speaker = tone & ~gap_q;
`else
   assign speaker = tone;
`endif

   always_ff @(posedge clk) begin
      if (!r) begin
         state      <= IDLE;
         beats_q    <= '0;
         bcnt       <= '0;
         note_ready <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (accept) begin
                  beats_q    <= note_beats;
                  bcnt       <= '0;
                  note_ready <= 1'b0;
                  busy       <= 1'b1;
                  state      <= PLAY;
               end
            end
            PLAY: begin
               if (finish) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= FIN;
               end else if (beat_in) begin
                  bcnt <= bcnt + DUR_BITS'(1);
               end
            end
            FIN: begin
               done       <= 1'b0;
               note_ready <= 1'b1;
               state      <= IDLE;
            end
            default: begin
               note_ready <= 1'b1;
               busy       <= 1'b0;
               done       <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule
